// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the serial configuration transmitter. It holds the
// FSM state type, the frame geometry and the default header bits. The
// frame_bit() helper maps a bit index to the bit sent on the wire.
// ---------------------------------------------------------------------------
package cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } cfg_state_e;

   localparam int          CFG_FRAME_BITS  = 5;
   localparam int          CFG_GAIN_W      = 3;
   localparam int          CFG_IDX_W       = 3;
   localparam logic [1:0]  CFG_HDR_DEFAULT = 2'b00;

   // The wire order is HDR[0], HDR[1], gain[2], gain[1], gain[0].
   function automatic logic frame_bit(input logic [1:0]            hdr,
                                      input logic [CFG_GAIN_W-1:0] gain,
                                      input logic [CFG_IDX_W-1:0]  idx);
      logic b;
      case (idx)
         3'd0:    b = hdr[0];
         3'd1:    b = hdr[1];
         3'd2:    b = gain[2];
         3'd3:    b = gain[1];
         3'd4:    b = gain[0];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sclk_phase_cnt.sv
// ---------------------------------------------------------------------------
// sclk_phase_cnt
// This is a terminal-count divider for the serial clock phases. While
// i_en=1, the module pulses o_phase_end for one cycle every SCLK_DIV cycles.
// While i_en=0, the count is held at 0, so every enable restarts from 0.
// Ports:
//   i_clk        system clock
//   i_resetbAll  synchronous active-low reset
//   i_en         count enable (a LOW or HIGH phase is in progress)
//   o_phase_end  combinational strobe on the last cycle of a phase
// ---------------------------------------------------------------------------
module sclk_phase_cnt #(
   parameter int SCLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_resetbAll,
   input  logic i_en,
   output logic o_phase_end
);

   localparam logic [7:0] LAST = 8'(SCLK_DIV - 1);

   logic [7:0] r_cnt;
   logic       w_phase_end;

   assign w_phase_end = i_en && (r_cnt == LAST);
   assign o_phase_end = w_phase_end;

   always_ff @(posedge i_clk) begin
      if (!i_resetbAll) begin
         r_cnt <= 8'd0;
      end else if (!i_en || w_phase_end) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/serial_cfg_tx.sv
// ---------------------------------------------------------------------------
// serial_cfg_tx
// This block frames a 3-bit gain word into a 5-bit serial stream
// (HDR[0], HDR[1], gain[2:0]). It drives the stream on o_sdin, using the
// serial clock o_sclk derived from i_clk. All outputs come from flops.
// Ports:
//   i_clk, i_resetbAll  clock and synchronous active-low reset
//   i_start, i_gain     one-cycle send request with its gain word
//   o_sclk, o_sdin      serial clock and data to the backend (idle low)
//   o_busy, o_done      frame in progress / one-cycle completion pulse
//   o_overrun           sticky flag set when an i_start is dropped
//   o_dbg_state         current FSM state, for observation only
// Handshake: i_start is accepted only in IDLE or DONE. Accepting it in DONE
// chains frames with no gap. An i_start seen in LOW or HIGH is dropped and
// sets o_overrun, which clears only on reset.
// ---------------------------------------------------------------------------
module serial_cfg_tx
   import cfg_pkg::*;
#(
   parameter int         SCLK_DIV = 2,
   parameter logic [1:0] HDR      = CFG_HDR_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_resetbAll,
   input  logic                  i_start,
   input  logic [CFG_GAIN_W-1:0] i_gain,
   output logic                  o_sclk,
   output logic                  o_sdin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overrun,
   output cfg_state_e            o_dbg_state
);

   localparam logic [CFG_IDX_W-1:0] LAST_IDX = CFG_IDX_W'(CFG_FRAME_BITS - 1);

   cfg_state_e            r_state;
   logic [CFG_IDX_W-1:0]  r_bit_idx;
   logic [CFG_GAIN_W-1:0] r_gain;
   logic                  r_sclk;
   logic                  r_sdin;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_overrun;
   logic                  w_en;
   logic                  w_phase_end;

   assign w_en = (r_state == LOW) || (r_state == HIGH);

   sclk_phase_cnt #(.SCLK_DIV(SCLK_DIV)) u_phase_cnt (
      .i_clk       (i_clk),
      .i_resetbAll (i_resetbAll),
      .i_en        (w_en),
      .o_phase_end (w_phase_end)
   );

   always_ff @(posedge i_clk) begin
      if (!i_resetbAll) begin
         r_state   <= IDLE;
         r_bit_idx <= '0;
         r_gain    <= '0;
         r_sclk    <= 1'b0;
         r_sdin    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            // DONE accepts a start exactly like IDLE, so frames chain back-to-back.
            IDLE, DONE: begin
               r_sclk <= 1'b0;
               if (i_start) begin
                  r_gain    <= i_gain;
                  r_bit_idx <= '0;
                  r_sdin    <= frame_bit(HDR, i_gain, '0);
                  r_busy    <= 1'b1;
                  r_state   <= LOW;
               end else begin
                  r_sdin  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            LOW: begin
               if (i_start) r_overrun <= 1'b1;
               if (w_phase_end) begin
                  r_sclk  <= 1'b1;
                  r_state <= HIGH;
               end
            end
            HIGH: begin
               if (i_start) r_overrun <= 1'b1;
               if (w_phase_end) begin
                  r_sclk <= 1'b0;
                  if (r_bit_idx == LAST_IDX) begin
                     r_sdin  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     // Data changes only here, while o_sclk falls to low.
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_sdin    <= frame_bit(HDR, r_gain, r_bit_idx + 3'd1);
                     r_state   <= LOW;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_sclk      = r_sclk;
   assign o_sdin      = r_sdin;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_overrun   = r_overrun;
   assign o_dbg_state = r_state;

endmodule
